sdram_core_arbiter: RTL and testbench
=====================================

Name: sdram_core_arbiter

Overview:
- N-port arbiter that merges NUM_PORTS SDRAM core managers onto one SDRAM core subordinate (controller) using the core request/accept/ack protocol.
- Selects one pending request (round-robin), holds it on the controller port until accepted, and returns each read completion (ack/error/read_data) to the port that issued it via an in-order tag FIFO.
- Sits between CPU/DMA/video masters and the single SDRAM controller.

Parameters:
NUM_PORTS, 4, number of manager ports (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
WORD_LEN, DATA_WIDTH/8, byte-enable width
MAX_OUTSTANDING, 4, max accepted-but-unacked reads (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_wr  in  NUM_PORTS*WORD_LEN  per-port byte write enables; port i at [i*WORD_LEN +: WORD_LEN]
m_rd  in  NUM_PORTS  per-port read request
m_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address
m_write_data  in  NUM_PORTS*DATA_WIDTH  per-port write data
m_accept  out  NUM_PORTS  request taken, one-cycle pulse
m_ack  out  NUM_PORTS  read completion pulse
m_error  out  NUM_PORTS  completion error, qualified by m_ack
m_read_data  out  DATA_WIDTH  read data, shared, valid with any m_ack bit
s_wr  out  WORD_LEN  to controller
s_rd  out  1  to controller
s_addr  out  ADDR_WIDTH  to controller
s_write_data  out  DATA_WIDTH  to controller
s_accept  in  1  controller took request
s_ack  in  1  controller read completion
s_error  in  1  controller error, with s_ack
s_read_data  in  DATA_WIDTH  controller read data

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, tag FIFO empty, round-robin pointer = 0.
- Port i requesting: |m_wr[i] or m_rd[i]. If both set, treated as write; rd ignored for that transaction.
- Read eligibility: read requests ignored while tag FIFO count == MAX_OUTSTANDING; writes always eligible.
- FSM IDLE: if any eligible request, register winner index (grant), its wr/rd/addr/write_data into s_* regs, go ISSUE. No request: stay, s_wr/s_rd = 0.
- FSM ISSUE: s_* held stable. On s_accept: m_accept[grant] = 1 same cycle (combinational), s_wr/s_rd cleared next edge, if read push grant into tag FIFO, rr pointer = grant+1 mod NUM_PORTS, go IDLE.
- Latency: request to s_rd/s_wr = 1 cycle; minimum request spacing on controller = 2 cycles.
- Manager must hold request until m_accept; deassertion before accept is a protocol violation (undefined).
- Round-robin: search starts at rr pointer, wraps at NUM_PORTS-1 -> 0.
- Completion: on s_ack, pop FIFO head h; next cycle m_ack[h] = 1, m_error[h] = s_error, m_read_data = s_read_data (registered). m_read_data holds last value otherwise.
- s_ack with empty FIFO: dropped, no m_ack.
- Push and pop same cycle: count unchanged. Full and pop same cycle: eligibility uses registered count, read still blocked that cycle.
- Writes produce no m_ack.
- Reset mid-transaction: request dropped, outstanding tags discarded; later s_ack dropped per empty rule.

Optional Feature:
SDRAM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest-index eligible port wins; rr pointer removed.
- Undefined: round-robin as above.

Test Plan:
- Single write: port 2 m_wr=4'hF, addr 0x100, data 0xDEADBEEF; s_accept 3 cycles after s_wr -> s_addr=0x100, s_write_data=0xDEADBEEF held, m_accept[2] single pulse, no m_ack.
- Read return: port 1 reads 0x40, s_ack with s_read_data 0x12345678 -> next cycle m_ack=4'b0010, m_read_data=0x12345678, m_error[1]=0.
- Round-robin: all 4 ports read continuously, s_accept immediate -> grant order 0,1,2,3,0; no port granted twice before all others served.
- Outstanding limit: port 0 issues 5 reads, no s_ack -> 4 accepted, 5th held (s_rd=0); one s_ack -> 5th issued within 2 cycles. Port 3 write proceeds while reads blocked.
- Error/ordering: reads from ports 3 then 0; s_ack with s_error=1 then s_ack with s_error=0 -> m_ack[3] with m_error[3]=1, then m_ack[0] with m_error[0]=0.
- Reset mid-ISSUE and spurious ack: rst_n low while s_rd=1 -> all outputs 0 immediately; after release, s_ack pulse -> no m_ack. With SDRAM_ARB_FIXED_PRIO_EN: ports 0 and 2 hold requests -> port 0 granted every time.

Source files
------------

// File: rtl/sdram_core_arbiter_if.sv
// Bus bundle between the SDRAM core arbiter and its managers/controller.
// slave = arbiter view; master = environment (managers plus controller) view.
interface sdram_core_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_LEN   = DATA_WIDTH / 8
);
  logic [NUM_PORTS*WORD_LEN-1:0]   m_wr;
  logic [NUM_PORTS-1:0]            m_rd;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] m_write_data;
  logic [NUM_PORTS-1:0]            m_accept;
  logic [NUM_PORTS-1:0]            m_ack;
  logic [NUM_PORTS-1:0]            m_error;
  logic [DATA_WIDTH-1:0]           m_read_data;

  logic [WORD_LEN-1:0]             s_wr;
  logic                            s_rd;
  logic [ADDR_WIDTH-1:0]           s_addr;
  logic [DATA_WIDTH-1:0]           s_write_data;
  logic                            s_accept;
  logic                            s_ack;
  logic                            s_error;
  logic [DATA_WIDTH-1:0]           s_read_data;

  modport slave (
    input  m_wr, m_rd, m_addr, m_write_data, s_accept, s_ack, s_error, s_read_data,
    output m_accept, m_ack, m_error, m_read_data, s_wr, s_rd, s_addr, s_write_data
  );

  modport master (
    output m_wr, m_rd, m_addr, m_write_data, s_accept, s_ack, s_error, s_read_data,
    input  m_accept, m_ack, m_error, m_read_data, s_wr, s_rd, s_addr, s_write_data
  );
endinterface

// File: rtl/sdram_core_arbiter.sv
// N-port SDRAM core arbiter: round-robin request merge, in-order tag FIFO routes read acks back.
// Define SDRAM_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module sdram_core_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORD_LEN        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rst_n,
  sdram_core_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int FW = $clog2(MAX_OUTSTANDING);
  localparam int CW = FW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state, next_state;
  logic [PW-1:0]         grant, winner;
  logic                  found;
  logic [NUM_PORTS-1:0]  port_wr, eligible;
  logic                  accept_now, push, pop, fifo_full;
  logic [CW-1:0]         count;
  logic [FW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         tag_mem [MAX_OUTSTANDING];

  logic [WORD_LEN-1:0]   sel_wr, s_wr_q;
  logic                  sel_rd, s_rd_q;
  logic [ADDR_WIDTH-1:0] sel_addr, s_addr_q;
  logic [DATA_WIDTH-1:0] sel_wdata, s_wdata_q, m_rdata_q;
  logic [NUM_PORTS-1:0]  m_ack_q, m_error_q;

  assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
  assign accept_now = (state == ISSUE) && bus.s_accept;
  assign push       = accept_now && s_rd_q;
  assign pop        = bus.s_ack && (count != '0);

  // A write wins over a simultaneous read; reads wait while the tag FIFO is full.
  always_comb begin
    port_wr  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_wr[i]  = |bus.m_wr[i*WORD_LEN +: WORD_LEN];
      eligible[i] = port_wr[i] | (bus.m_rd[i] & ~fifo_full);
    end
  end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found  = 1'b1;
        winner = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr;

  always_comb begin
    logic [PW:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (!found && eligible[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (accept_now)
      rr_ptr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
  end
`endif

  always_comb begin
    sel_wr    = '0;
    sel_rd    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner == PW'(i)) begin
        sel_wr    = bus.m_wr[i*WORD_LEN +: WORD_LEN];
        sel_rd    = bus.m_rd[i] & ~port_wr[i];
        sel_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.m_write_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = ISSUE;
      ISSUE:   if (bus.s_accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.m_accept = '0;
    if (accept_now) bus.m_accept[grant] = 1'b1;
  end

  // Controller-side request registers stay frozen for the whole ISSUE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      s_wr_q    <= '0;
      s_rd_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else if (state == IDLE && found) begin
      grant     <= winner;
      s_wr_q    <= sel_wr;
      s_rd_q    <= sel_rd;
      s_addr_q  <= sel_addr;
      s_wdata_q <= sel_wdata;
    end else if (accept_now) begin
      s_wr_q <= '0;
      s_rd_q <= 1'b0;
    end
  end

  assign bus.s_wr         = s_wr_q;
  assign bus.s_rd         = s_rd_q;
  assign bus.s_addr       = s_addr_q;
  assign bus.s_write_data = s_wdata_q;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Completions are routed to the port at the FIFO head; acks with nothing outstanding vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack_q   <= '0;
      m_error_q <= '0;
      m_rdata_q <= '0;
    end else begin
      m_ack_q   <= '0;
      m_error_q <= '0;
      if (pop) begin
        m_ack_q[tag_mem[rd_ptr]]   <= 1'b1;
        m_error_q[tag_mem[rd_ptr]] <= bus.s_error;
        m_rdata_q                  <= bus.s_read_data;
      end
    end
  end

  assign bus.m_ack       = m_ack_q;
  assign bus.m_error     = m_error_q;
  assign bus.m_read_data = m_rdata_q;
endmodule

// File: tb/tb_sdram_core_arbiter.sv
// Directed testbench for sdram_core_arbiter (4 ports, 32-bit, 4 outstanding reads).
module tb_sdram_core_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  sdram_core_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL)) bus ();

  sdram_core_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL), .MAX_OUTSTANDING(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_wr         = '0;
    bus.m_rd         = '0;
    bus.m_addr       = '0;
    bus.m_write_data = '0;
    bus.s_accept     = 1'b0;
    bus.s_ack        = 1'b0;
    bus.s_error      = 1'b0;
    bus.s_read_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    bus.s_accept = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.s_wr, bus.s_rd, bus.s_addr, bus.s_write_data} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_s_bus: got wr=%h rd=%b addr=%h data=%h expected all 0",
               bus.s_wr, bus.s_rd, bus.s_addr, bus.s_write_data);
    end
    checks++;
    if ({bus.m_accept, bus.m_ack, bus.m_error, bus.m_read_data} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_m_bus: got accept=%b ack=%b err=%b rdata=%h expected all 0",
               bus.m_accept, bus.m_ack, bus.m_error, bus.m_read_data);
    end
    bus.s_accept = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int pulses;
    do_reset();
    bus.m_wr[2*WL +: WL]         = 4'hF;
    bus.m_addr[2*AW +: AW]       = 32'h100;
    bus.m_write_data[2*DW +: DW] = 32'hDEADBEEF;
    pulses = 0;
    tick();
    checks++;
    if (bus.s_wr !== 4'hF || bus.s_rd !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_issue: got wr=%h rd=%b expected wr=f rd=0", bus.s_wr, bus.s_rd);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.s_addr !== 32'h100 || bus.s_write_data !== 32'hDEADBEEF || bus.s_wr !== 4'hF) begin
        failures++;
        $display("[TB] FAIL write_hold: got addr=%h data=%h wr=%h expected 00000100 deadbeef f",
                 bus.s_addr, bus.s_write_data, bus.s_wr);
      end
      if (bus.m_accept != '0) pulses++;
      if (c < 2) tick();
    end
    bus.s_accept = 1'b1;
    #1;
    checks++;
    if (bus.m_accept !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL write_accept: got %b expected 0100", bus.m_accept);
    end
    if (bus.m_accept != '0) pulses++;
    tick();
    bus.m_wr = '0;
    bus.s_accept = 1'b0;
    checks++;
    if (bus.s_wr !== 4'h0) begin
      failures++;
      $display("[TB] FAIL write_clear: got wr=%h expected 0", bus.s_wr);
    end
    for (int c = 0; c < 3; c++) begin
      if (bus.m_accept != '0) pulses++;
      checks++;
      if (bus.m_ack !== '0) begin
        failures++;
        $display("[TB] FAIL write_no_ack: got %b expected 0000", bus.m_ack);
      end
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("[TB] FAIL write_accept_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_read_return();
    do_reset();
    bus.m_rd[1]            = 1'b1;
    bus.m_addr[1*AW +: AW] = 32'h40;
    tick();
    checks++;
    if (bus.s_rd !== 1'b1 || bus.s_addr !== 32'h40 || bus.s_wr !== 4'h0) begin
      failures++;
      $display("[TB] FAIL read_issue: got rd=%b addr=%h wr=%h expected 1 00000040 0",
               bus.s_rd, bus.s_addr, bus.s_wr);
    end
    bus.s_accept = 1'b1;
    #1;
    checks++;
    if (bus.m_accept !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL read_accept: got %b expected 0010", bus.m_accept);
    end
    tick();
    bus.m_rd         = '0;
    bus.s_accept     = 1'b0;
    bus.s_ack        = 1'b1;
    bus.s_read_data  = 32'h12345678;
    checks++;
    if (bus.m_ack !== '0) begin
      failures++;
      $display("[TB] FAIL read_ack_early: got %b expected 0000", bus.m_ack);
    end
    tick();
    bus.s_ack = 1'b0;
    checks++;
    if (bus.m_ack !== 4'b0010 || bus.m_read_data !== 32'h12345678 || bus.m_error !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL read_ack: got ack=%b rdata=%h err=%b expected 0010 12345678 0000",
               bus.m_ack, bus.m_read_data, bus.m_error);
    end
    bus.s_read_data = 32'hFFFF0000;
    tick();
    checks++;
    if (bus.m_ack !== '0 || bus.m_read_data !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL read_data_hold: got ack=%b rdata=%h expected 0000 12345678",
               bus.m_ack, bus.m_read_data);
    end
  endtask

  task automatic test_round_robin();
    int exp_port [5];
    logic [NP-1:0] got_acc  [5];
    logic [AW-1:0] got_addr [5];
    int n;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_port = '{0, 0, 0, 0, 0};
`else
    exp_port = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int p = 0; p < NP; p++) bus.m_addr[p*AW +: AW] = 32'h1000 + 32'(p * 16);
    bus.m_rd     = 4'b1111;
    bus.s_accept = 1'b1;
    bus.s_ack    = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      tick();
      if (bus.m_accept != '0) begin
        got_acc[n]  = bus.m_accept;
        got_addr[n] = bus.s_addr;
        n++;
      end
    end
    clear_inputs();
    checks++;
    if (n !== 5) begin
      failures++;
      $display("[TB] FAIL rr_grant_count: got %0d expected 5", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_acc[i] !== NP'(1 << exp_port[i]) || got_addr[i] !== 32'h1000 + 32'(exp_port[i] * 16)) begin
        failures++;
        $display("[TB] FAIL rr_grant_%0d: got accept=%b addr=%h expected port %0d addr=%h",
                 i, got_acc[i], got_addr[i], exp_port[i], 32'h1000 + 32'(exp_port[i] * 16));
      end
    end
    tick();
  endtask

  task automatic test_outstanding_limit();
    int n;
    do_reset();
    bus.m_rd[0]            = 1'b1;
    bus.m_addr[0*AW +: AW] = 32'h200;
    bus.s_accept           = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.m_accept[0]) n++;
    end
    checks++;
    if (n !== 4 || bus.s_rd !== 1'b0) begin
      failures++;
      $display("[TB] FAIL limit_fill: got accepts=%0d rd=%b expected 4 0", n, bus.s_rd);
    end
    bus.m_wr[3*WL +: WL]         = 4'hF;
    bus.m_addr[3*AW +: AW]       = 32'h300;
    bus.m_write_data[3*DW +: DW] = 32'hCAFEF00D;
    tick();
    checks++;
    if (bus.m_accept !== 4'b1000 || bus.s_wr !== 4'hF || bus.s_rd !== 1'b0 || bus.s_write_data !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL limit_write: got accept=%b wr=%h rd=%b data=%h expected 1000 f 0 cafef00d",
               bus.m_accept, bus.s_wr, bus.s_rd, bus.s_write_data);
    end
    tick();
    bus.m_wr = '0;
    checks++;
    if (bus.s_rd !== 1'b0 || bus.s_wr !== 4'h0) begin
      failures++;
      $display("[TB] FAIL limit_blocked: got rd=%b wr=%h expected 0 0", bus.s_rd, bus.s_wr);
    end
    bus.s_ack       = 1'b1;
    bus.s_read_data = 32'h0BADF00D;
    tick();
    bus.s_ack = 1'b0;
    checks++;
    if (bus.m_ack !== 4'b0001 || bus.s_rd !== 1'b0) begin
      failures++;
      $display("[TB] FAIL limit_pop_cycle: got ack=%b rd=%b expected 0001 0", bus.m_ack, bus.s_rd);
    end
    tick();
    checks++;
    if (bus.s_rd !== 1'b1 || bus.m_accept !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL limit_resume: got rd=%b accept=%b expected 1 0001", bus.s_rd, bus.m_accept);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_error_order();
    do_reset();
    bus.m_rd[3]  = 1'b1;
    bus.s_accept = 1'b1;
    tick();
    checks++;
    if (bus.m_accept !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL order_accept3: got %b expected 1000", bus.m_accept);
    end
    tick();
    bus.m_rd[3] = 1'b0;
    bus.m_rd[0] = 1'b1;
    tick();
    checks++;
    if (bus.m_accept !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL order_accept0: got %b expected 0001", bus.m_accept);
    end
    tick();
    bus.m_rd        = '0;
    bus.s_accept    = 1'b0;
    bus.s_ack       = 1'b1;
    bus.s_error     = 1'b1;
    bus.s_read_data = 32'hA5A5A5A5;
    tick();
    bus.s_error     = 1'b0;
    bus.s_read_data = 32'h5A5A5A5A;
    checks++;
    if (bus.m_ack !== 4'b1000 || bus.m_error !== 4'b1000 || bus.m_read_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("[TB] FAIL order_first: got ack=%b err=%b rdata=%h expected 1000 1000 a5a5a5a5",
               bus.m_ack, bus.m_error, bus.m_read_data);
    end
    tick();
    bus.s_ack = 1'b0;
    checks++;
    if (bus.m_ack !== 4'b0001 || bus.m_error !== 4'b0000 || bus.m_read_data !== 32'h5A5A5A5A) begin
      failures++;
      $display("[TB] FAIL order_second: got ack=%b err=%b rdata=%h expected 0001 0000 5a5a5a5a",
               bus.m_ack, bus.m_error, bus.m_read_data);
    end
    tick();
    checks++;
    if (bus.m_ack !== '0) begin
      failures++;
      $display("[TB] FAIL order_drained: got %b expected 0000", bus.m_ack);
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    bus.m_rd[2]            = 1'b1;
    bus.m_addr[2*AW +: AW] = 32'h20;
    bus.s_accept           = 1'b1;
    tick();
    tick();
    bus.m_rd[2]            = 1'b0;
    bus.s_accept           = 1'b0;
    bus.s_ack              = 1'b1;
    bus.s_read_data        = 32'h77777777;
    bus.m_rd[1]            = 1'b1;
    bus.m_addr[1*AW +: AW] = 32'h10;
    tick();
    bus.s_ack = 1'b0;
    checks++;
    if (bus.s_rd !== 1'b1 || bus.m_read_data !== 32'h77777777) begin
      failures++;
      $display("[TB] FAIL midreset_setup: got rd=%b rdata=%h expected 1 77777777", bus.s_rd, bus.m_read_data);
    end
    bus.m_rd[0]  = 1'b1;
    bus.s_accept = 1'b1;
    rst_n        = 1'b0;
    #1;
    checks++;
    if ({bus.s_wr, bus.s_rd, bus.s_addr, bus.s_write_data, bus.m_accept, bus.m_ack, bus.m_error, bus.m_read_data} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got rd=%b addr=%h accept=%b ack=%b rdata=%h expected all 0",
               bus.s_rd, bus.s_addr, bus.m_accept, bus.m_ack, bus.m_read_data);
    end
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    bus.s_ack = 1'b1;
    tick();
    bus.s_ack = 1'b0;
    tick();
    checks++;
    if (bus.m_ack !== '0) begin
      failures++;
      $display("[TB] FAIL spurious_ack: got %b expected 0000", bus.m_ack);
    end
  endtask

  task automatic test_two_port();
    int exp_port [4];
    logic [NP-1:0] got_acc [4];
    int n;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_port = '{0, 0, 0, 0};
`else
    exp_port = '{0, 2, 0, 2};
`endif
    do_reset();
    bus.m_wr[0*WL +: WL] = 4'hF;
    bus.m_wr[2*WL +: WL] = 4'h3;
    bus.s_accept         = 1'b1;
    n = 0;
    for (int c = 0; c < 16 && n < 4; c++) begin
      tick();
      if (bus.m_accept != '0) begin
        got_acc[n] = bus.m_accept;
        n++;
      end
    end
    clear_inputs();
    checks++;
    if (n !== 4) begin
      failures++;
      $display("[TB] FAIL two_port_count: got %0d expected 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_acc[i] !== NP'(1 << exp_port[i])) begin
        failures++;
        $display("[TB] FAIL two_port_grant_%0d: got %b expected port %0d", i, got_acc[i], exp_port[i]);
      end
    end
    tick();
  endtask

  initial begin
    clear_inputs();
    $display("[TB] starting sdram_core_arbiter directed tests");
    test_reset();
    test_single_write();
    test_read_return();
    test_round_robin();
    test_outstanding_limit();
    test_error_order();
    test_reset_mid_issue();
    test_two_port();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
